// File: rtl/quad_pkg.sv
// +------------------------------------------------------------------+
// | quad_pkg : shared quad-rotor widths and ESC PWM timing defaults  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package quad_pkg;

    localparam int SPD_W          = 11;
    localparam int ESC_FRAME_CLKS = 62500;   // 800 Hz frame at 50 MHz
    localparam int ESC_BASE_CLKS  = 6250;
    localparam int ESC_SCALE      = 3;
    localparam int ESC_CNT_W      = 17;

    typedef logic [SPD_W-1:0] spd_t;

endpackage

`default_nettype wire

// File: rtl/esc_pwm_chan.sv
// +------------------------------------------------------------------+
// | esc_pwm_chan : one ESC channel - shadow/active speed, registered |
// | pulse compare. Rev 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none

module esc_pwm_chan
    import quad_pkg::*;
#(
    parameter int BASE_CLKS = ESC_BASE_CLKS,
    parameter int SCALE     = ESC_SCALE,
    parameter int CNT_W     = ESC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frm_load,
    input  logic             i_wrt,
    input  logic             i_armed_act,
    input  spd_t             i_spd,
    input  logic [CNT_W-1:0] i_frame_cnt,
    output logic             o_pwm
);

    spd_t             r_shadow;
    spd_t             r_active;
    logic             r_pwm;
    spd_t             w_spd_eff;
    logic [CNT_W-1:0] w_cmp;

    assign w_spd_eff = i_armed_act ? r_active : '0;
    assign w_cmp     = CNT_W'(BASE_CLKS) + CNT_W'(SCALE) * CNT_W'(w_spd_eff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            // Shadow also follows a bypassed write so the value persists into later frames.
            if (i_wrt)
                r_shadow <= i_spd;
            if (i_frm_load)
                r_active <= i_wrt ? i_spd : r_shadow;
            r_pwm <= (i_frame_cnt < w_cmp);
        end
    end

    assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/esc_pwm_bank.sv
// +------------------------------------------------------------------+
// | esc_pwm_bank : four frame-synchronous ESC PWM outputs with       |
// | double-buffered speed updates. Rev 1.0                           |
// +------------------------------------------------------------------+
`default_nettype none

module esc_pwm_bank
    import quad_pkg::*;
#(
    parameter int FRAME_CLKS = ESC_FRAME_CLKS,
    parameter int BASE_CLKS  = ESC_BASE_CLKS,
    parameter int SCALE      = ESC_SCALE,
    parameter int CNT_W      = ESC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrt,
    input  logic             armed,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             frnt_pwm,
    output logic             bck_pwm,
    output logic             lft_pwm,
    output logic             rght_pwm,
    output logic             frm_strt,
    output logic             upd_pend
);

    localparam int C_NCHAN = 4;

    logic [CNT_W-1:0]              r_frame_cnt;
    logic                          r_armed_act;
    logic                          r_frm_strt;
    logic                          r_upd_pend;
    logic                          w_frm_load;
    logic [C_NCHAN-1:0][SPD_W-1:0] w_spd;
    logic [C_NCHAN-1:0]            w_pwm;

    // Wrap edge; the reset edge is the other frame start but clears everything anyway.
    assign w_frm_load = (r_frame_cnt == CNT_W'(FRAME_CLKS - 1));
    assign w_spd      = {rght_spd, lft_spd, bck_spd, frnt_spd};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_armed_act <= 1'b0;
            r_frm_strt  <= 1'b0;
            r_upd_pend  <= 1'b0;
        end else begin
            r_frame_cnt <= w_frm_load ? '0 : r_frame_cnt + CNT_W'(1);
            if (w_frm_load)
                r_armed_act <= armed;
            r_frm_strt <= (r_frame_cnt == '0);
            if (w_frm_load)
                r_upd_pend <= 1'b0;
            else if (wrt)
                r_upd_pend <= 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < C_NCHAN; g++) begin : g_chan
            esc_pwm_chan #(
                .BASE_CLKS (BASE_CLKS),
                .SCALE     (SCALE),
                .CNT_W     (CNT_W)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_frm_load  (w_frm_load),
                .i_wrt       (wrt),
                .i_armed_act (r_armed_act),
                .i_spd       (w_spd[g]),
                .i_frame_cnt (r_frame_cnt),
                .o_pwm       (w_pwm[g])
            );
        end
    endgenerate

    assign frnt_pwm = w_pwm[0];
    assign bck_pwm  = w_pwm[1];
    assign lft_pwm  = w_pwm[2];
    assign rght_pwm = w_pwm[3];
    assign frm_strt = r_frm_strt;
    assign upd_pend = r_upd_pend;

endmodule

`default_nettype wire

// File: tb/tb_esc_pwm_bank.sv
// +------------------------------------------------------------------+
// | tb_esc_pwm_bank : self-checking bench for esc_pwm_bank (reduced  |
// | frame length). Rev 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_esc_pwm_bank;

    localparam int FRAME = 2500;
    localparam int BASE  = 250;
    localparam int SCALE = 1;
    localparam int CW    = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wrt = 1'b0;
    logic             armed = 1'b0;
    logic [3:0][10:0] sp;
    logic             frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frm_strt, upd_pend;
    logic [3:0]       pwm_v;

    assign pwm_v = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};

    esc_pwm_bank #(
        .FRAME_CLKS (FRAME),
        .BASE_CLKS  (BASE),
        .SCALE      (SCALE),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt      (wrt),
        .armed    (armed),
        .frnt_spd (sp[0]),
        .bck_spd  (sp[1]),
        .lft_spd  (sp[2]),
        .rght_spd (sp[3]),
        .frnt_pwm (frnt_pwm),
        .bck_pwm  (bck_pwm),
        .lft_pwm  (lft_pwm),
        .rght_pwm (rght_pwm),
        .frm_strt (frm_strt),
        .upd_pend (upd_pend)
    );

    always #5 clk = ~clk;

    // Reference model: position in frame plus the speed buffers, applied per edge.
    int k = 0;
    int shadow [4];
    int active [4];
    bit arm_act = 0;
    bit pend = 0;
    int hcnt [4];
    int last_w [4];
    int cyc = 0;
    int prev_fs = -1;
    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [3:0][10:0] spd;
        logic             arm;
        logic [3:0][15:0] w;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s cyc=%0d k=%0d got=%0d exp=%0d", name, cyc, k, got, exp);
        end
    endtask

    function automatic int exp_width(input int c);
        return BASE + SCALE * (arm_act ? active[c] : 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            k = 0; arm_act = 0; pend = 0; prev_fs = -1;
            for (int c = 0; c < 4; c++) begin shadow[c] = 0; active[c] = 0; end
        end else if (k == FRAME - 1) begin
            k = 0; arm_act = armed; pend = 0;
            for (int c = 0; c < 4; c++) begin
                active[c] = wrt ? int'(sp[c]) : shadow[c];
                if (wrt) shadow[c] = int'(sp[c]);
            end
        end else begin
            k++;
            if (wrt) begin
                pend = 1;
                for (int c = 0; c < 4; c++) shadow[c] = int'(sp[c]);
            end
        end
        @(negedge clk);
        for (int c = 0; c < 4; c++)
            check($sformatf("pwm%0d", c), int'(pwm_v[c]), int'(k >= 1 && k <= exp_width(c)));
        check("frm_strt", int'(frm_strt), int'(k == 1));
        check("upd_pend", int'(upd_pend), int'(pend));
        if (frm_strt) begin
            if (prev_fs >= 0) check("fs_period", cyc - prev_fs, FRAME);
            prev_fs = cyc;
        end
        for (int c = 0; c < 4; c++) begin
            if (k == 0) begin last_w[c] = hcnt[c]; hcnt[c] = 0; end
            else hcnt[c] += int'(pwm_v[c]);
        end
    endtask

    task automatic run_to(input int target);
        int n = 0;
        do begin tick(); n++; end while (k != target && n < 3 * FRAME);
        if (k != target) check("run_to_timeout", k, target);
    endtask

    task automatic set_spd(input int f, input int b, input int l, input int r);
        sp[0] = 11'(f); sp[1] = 11'(b); sp[2] = 11'(l); sp[3] = 11'(r);
    endtask

    task automatic pulse_wrt();
        wrt = 1'b1; tick(); wrt = 1'b0;
    endtask

    initial begin
        int prev_exp [4];
        for (int c = 0; c < 4; c++) begin hcnt[c] = 0; last_w[c] = 0; prev_exp[c] = BASE; end
        set_spd(0, 0, 0, 0);

        tbl[0] = '{spd: {11'd1, 11'd1000, 11'd0, 11'd2047}, arm: 1'b1,
                   w: {16'(BASE + 1), 16'(BASE + 1000), 16'(BASE), 16'(BASE + 2047)}};
        tbl[1] = '{spd: {11'd8, 11'd7, 11'd6, 11'd5}, arm: 1'b0,
                   w: {16'(BASE), 16'(BASE), 16'(BASE), 16'(BASE)}};
        tbl[2] = '{spd: {11'd1000, 11'd1000, 11'd1000, 11'd1000}, arm: 1'b1,
                   w: {16'(BASE + 1000), 16'(BASE + 1000), 16'(BASE + 1000), 16'(BASE + 1000)}};

        // Reset and idle frames with armed but no write: every channel at base width.
        armed = 1'b1;
        repeat (3) tick();
        check("rst_pwm", int'(pwm_v), 0);
        check("rst_frm_strt", int'(frm_strt), 0);
        check("rst_upd_pend", int'(upd_pend), 0);
        rst_n = 1'b1;
        run_to(0);
        run_to(0);
        for (int c = 0; c < 4; c++) check("idle_width", last_w[c], BASE);

        // Table: mid-frame write, current frame unchanged, next frame at new widths.
        for (int i = 0; i < 3; i++) begin
            run_to(100);
            armed = tbl[i].arm;
            sp = tbl[i].spd;
            pulse_wrt();
            check("tbl_pend_set", int'(upd_pend), 1);
            run_to(0);
            for (int c = 0; c < 4; c++) check("tbl_cur_frame", last_w[c], prev_exp[c]);
            check("tbl_pend_clr", int'(upd_pend), 0);
            run_to(0);
            for (int c = 0; c < 4; c++) begin
                check("tbl_new_width", last_w[c], int'(tbl[i].w[c]));
                prev_exp[c] = int'(tbl[i].w[c]);
            end
        end

        // armed low with speed 1000, then raised mid-frame: only the next frame widens.
        armed = 1'b0;
        set_spd(1000, 1000, 1000, 1000);
        run_to(10);
        pulse_wrt();
        run_to(0);
        run_to(0);
        check("disarmed_width", last_w[2], BASE);
        run_to(400);
        armed = 1'b1;
        run_to(0);
        check("arm_cur_frame", last_w[2], BASE);
        run_to(0);
        check("arm_next_frame", last_w[2], BASE + 1000);

        // Write in the last cycle of a frame bypasses the shadow; pending never set.
        set_spd(100, 1000, 1000, 1000);
        run_to(FRAME - 1);
        pulse_wrt();
        check("bypass_pend", int'(upd_pend), 0);
        run_to(0);
        check("bypass_width", last_w[0], BASE + 100);

        // Two writes in one frame: the last one wins.
        run_to(50);
        set_spd(500, 1000, 1000, 1000);
        pulse_wrt();
        run_to(900);
        set_spd(800, 1000, 1000, 1000);
        pulse_wrt();
        run_to(0);
        run_to(0);
        check("double_wrt_width", last_w[0], BASE + 800);

        // Reset in the middle of a pulse aborts it; following frame at base width.
        run_to(700);
        check("pre_rst_pwm", int'(frnt_pwm), 1);
        rst_n = 1'b0;
        tick();
        check("rst_abort_pwm", int'(pwm_v), 0);
        rst_n = 1'b1;
        run_to(0);
        for (int c = 0; c < 4; c++) check("post_rst_width", last_w[c], BASE);

        // Random writes and arming changes, checked cycle by cycle against the model.
        for (int n = 0; n < 8 * FRAME; n++) begin
            if ($urandom_range(0, 299) == 0 || (k == FRAME - 1 && $urandom_range(0, 1) == 0)) begin
                for (int c = 0; c < 4; c++) sp[c] = 11'($urandom_range(0, 2047));
                wrt = 1'b1;
            end else begin
                wrt = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) armed = ~armed;
            tick();
        end
        wrt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
